bus_reg_bank: RTL and testbench

Parametrised bank of general-purpose datapath registers sharing one internal bus. It supersedes the hand-instantiated per-register latch/enable wiring and the tristate bus driver. A step-qualified transfer sequencer moves one word per command: register-to-register, external-to-register, increment, or clear. The bank sits between the clock pulser (which supplies `step`) and the LED/debug tap.

---
 rtl/fpg8_pkg.sv | 19 +
 rtl/bus_reg_bank_if.sv | 33 +++
 rtl/bus_xfer_fsm.sv | 86 ++++++++
 rtl/bus_reg_bank.sv | 103 ++++++++++
 tb/tb_bus_reg_bank.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fpg8_pkg.sv
// fpg8 shared definitions: transfer op codes,
// sequencer states and default bank geometry.
package fpg8_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREGS = 10;

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_LATCH
  } state_t;

endpackage

// File: rtl/bus_reg_bank_if.sv
// Command/bus bundle between the transfer
// master and the register bank.
interface bus_reg_bank_if
  import fpg8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = 4
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [SEL_W-1:0] cmd_src;
  logic [SEL_W-1:0] cmd_dst;
  logic [WIDTH-1:0] ext_data;
  logic [WIDTH-1:0] bus;
  logic             done;
  logic             err;
  logic             carry;

  modport master (
    output cmd_valid, cmd_op, cmd_src,
    output cmd_dst, ext_data,
    input  cmd_ready, bus, done, err, carry
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_src,
    input  cmd_dst, ext_data,
    output cmd_ready, bus, done, err, carry
  );

endinterface

// File: rtl/bus_xfer_fsm.sv
// Step-qualified IDLE->DRIVE->LATCH sequencer
// with command capture and index check.
module bus_xfer_fsm
  import fpg8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS,
  parameter int SEL_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [SEL_W-1:0] cmd_src,
  input  logic [SEL_W-1:0] cmd_dst,
  input  logic [WIDTH-1:0] ext_data,
  output logic             cmd_ready,
  output logic             drive_en,
  output logic             write_en,
  output logic             illegal,
  output logic [1:0]       op,
  output logic [SEL_W-1:0] src,
  output logic [SEL_W-1:0] dst,
  output logic [WIDTH-1:0] data
);

  state_t state, state_nx;
  logic   accept;
  logic   bad;

  // src only matters for ops that read a register
  always_comb begin
    bad = int'(cmd_dst) >= NREGS;
    if (cmd_op == OP_MOV || cmd_op == OP_INC)
      bad = bad || (int'(cmd_src) >= NREGS);
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    drive_en = 1'b0;
    write_en = 1'b0;
    unique case (state)
      ST_IDLE:
        if (step && cmd_valid) begin
          accept   = 1'b1;
          state_nx = ST_DRIVE;
        end
      ST_DRIVE:
        if (step) begin
          drive_en = 1'b1;
          state_nx = ST_LATCH;
        end
      ST_LATCH:
        if (step) begin
          write_en = 1'b1;
          state_nx = ST_IDLE;
        end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      op      <= OP_MOV;
      src     <= '0;
      dst     <= '0;
      data    <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op      <= cmd_op;
        src     <= cmd_src;
        dst     <= cmd_dst;
        data    <= ext_data;
        illegal <= bad;
      end
    end
  end

endmodule

// File: rtl/bus_reg_bank.sv
// Register bank on a shared registered bus,
// one word moved per command.
module bus_reg_bank
  import fpg8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS,
  localparam int SEL_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step,
  bus_reg_bank_if.slave    bif,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] bus_q;
  logic [WIDTH-1:0] src_val;
  logic [WIDTH-1:0] drv_val;
  logic [WIDTH-1:0] wr_val;
  logic [WIDTH:0]   inc;
  logic             carry_q, done_q, err_q;

  logic             drive_en, write_en, illegal;
  logic [1:0]       op;
  logic [SEL_W-1:0] src, dst;
  logic [WIDTH-1:0] data;

  bus_xfer_fsm #(
    .WIDTH(WIDTH),
    .NREGS(NREGS),
    .SEL_W(SEL_W)
  ) u_fsm (
    .clk      (clk),
    .reset_n  (reset_n),
    .step     (step),
    .cmd_valid(bif.cmd_valid),
    .cmd_op   (bif.cmd_op),
    .cmd_src  (bif.cmd_src),
    .cmd_dst  (bif.cmd_dst),
    .ext_data (bif.ext_data),
    .cmd_ready(bif.cmd_ready),
    .drive_en (drive_en),
    .write_en (write_en),
    .illegal  (illegal),
    .op       (op),
    .src      (src),
    .dst      (dst),
    .data     (data)
  );

  assign src_val = (int'(src) < NREGS)
                 ? regs[src] : '0;

  always_comb begin
    drv_val = '0;
    if (!illegal) begin
      unique case (1'b1)
        (op == OP_MOV),
        (op == OP_INC):  drv_val = src_val;
        (op == OP_LOAD): drv_val = data;
        default:         drv_val = '0;
      endcase
    end
  end

  assign inc    = {1'b0, bus_q} + (WIDTH+1)'(1);
  assign wr_val = (op == OP_INC)
                ? inc[WIDTH-1:0] : bus_q;

  // done/err are plain pulses, not gated by step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      bus_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= write_en;
      err_q  <= write_en && illegal;
      if (drive_en)
        bus_q <= drv_val;
      if (write_en && !illegal) begin
        regs[dst] <= wr_val;
        if (op == OP_INC)
          carry_q <= inc[WIDTH];
      end
    end
  end

  assign rd_data = (int'(rd_sel) < NREGS)
                 ? regs[rd_sel] : '0;

  assign bif.bus   = bus_q;
  assign bif.done  = done_q;
  assign bif.err   = err_q;
  assign bif.carry = carry_q;

endmodule

// File: tb/tb_bus_reg_bank.sv
// Scoreboard bench for bus_reg_bank:
// reference model, step gating, reset abort.
module tb_bus_reg_bank;
  import fpg8_pkg::*;

  localparam int W  = 16;
  localparam int N  = 10;
  localparam int SW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          step = 1'b0;
  logic [SW-1:0] rd_sel = '0;
  logic [W-1:0]  rd_data;

  bus_reg_bank_if #(.WIDTH(W), .SEL_W(SW)) bif();

  bus_reg_bank #(.WIDTH(W), .NREGS(N)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .step   (step),
    .bif    (bif),
    .rd_sel (rd_sel),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         err;
    logic [W-1:0] bus;
    logic [W-1:0] val;
    int           dst;
    logic         carry;
  } exp_t;

  exp_t         sb [$];
  logic [W-1:0] m [N];
  logic         m_carry;
  int           n_chk = 0;
  int           n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      rd_sel = SW'(i);
      #1;
      chk($sformatf("reg%0d", i), rd_data, m[i]);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op,
                         input int src,
                         input int dst,
                         input logic [W-1:0] d);
    exp_t e;
    int   n;
    logic legal;
    legal = (dst < N) &&
            !((op == OP_MOV || op == OP_INC)
              && src >= N);
    e.err   = !legal;
    e.dst   = dst;
    e.carry = m_carry;
    e.bus   = '0;
    e.val   = '0;
    if (legal) begin
      case (op)
        OP_MOV: begin
          e.bus = m[src];
          e.val = m[src];
        end
        OP_LOAD: begin
          e.bus = d;
          e.val = d;
        end
        OP_INC: begin
          e.bus   = m[src];
          e.val   = m[src] + 16'd1;
          e.carry = (m[src] == 16'hFFFF);
        end
        default: ;
      endcase
    end
    sb.push_back(e);

    @(negedge clk);
    chk("ready_idle", bif.cmd_ready, 1);
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = op;
    bif.cmd_src   = SW'(src);
    bif.cmd_dst   = SW'(dst);
    bif.ext_data  = d;
    step          = 1'b1;
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    chk("ready_busy", bif.cmd_ready, 0);
    n = 0;
    while (!bif.done && n < 8) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("bus_drv", bif.bus, e.bus);
    end
    e = sb.pop_front();
    if (!bif.done) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("latency", n, 2);
      chk("err", bif.err, e.err);
      chk("bus", bif.bus, e.bus);
      chk("carry", bif.carry, e.carry);
      chk("ready_back", bif.cmd_ready, 1);
      m_carry = e.carry;
      if (!e.err) begin
        m[e.dst] = e.val;
        rd_sel = SW'(e.dst);
        #1;
        chk("rd_dst", rd_data, e.val);
      end
      @(negedge clk);
      chk("done_pulse", bif.done, 0);
      chk("err_pulse", bif.err, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  logic [5:0] pat;

  initial begin
    bif.cmd_valid = 1'b0;
    bif.cmd_op    = OP_MOV;
    bif.cmd_src   = '0;
    bif.cmd_dst   = '0;
    bif.ext_data  = '0;
    for (int i = 0; i < N; i++) m[i] = '0;
    m_carry = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_bus", bif.bus, 0);
    chk("rst_done", bif.done, 0);
    chk("rst_err", bif.err, 0);
    chk("rst_carry", bif.carry, 0);
    chk("rst_ready", bif.cmd_ready, 1);
    reset_n = 1'b1;

    run_cmd(OP_LOAD, 0, 3, 16'h5500);
    check_all();
    run_cmd(OP_MOV, 3, 7, '0);
    run_cmd(OP_LOAD, 0, 2, 16'hFFFF);
    run_cmd(OP_INC, 2, 2, '0);
    run_cmd(OP_LOAD, 0, 2, 16'h0001);
    run_cmd(OP_INC, 2, 2, '0);
    run_cmd(OP_INC, 7, 9, '0);
    run_cmd(OP_MOV, 3, 12, '0);
    run_cmd(OP_INC, 11, 1, '0);
    run_cmd(OP_CLR, 14, 7, '0);
    run_cmd(OP_LOAD, 0, 15, 16'h1234);
    run_cmd(OP_MOV, 9, 9, '0);
    check_all();

    for (int k = 0; k < 10; k++)
      run_cmd(2'($urandom_range(0, 3)),
              $urandom_range(0, 11),
              $urandom_range(0, 11),
              W'($urandom));
    check_all();

    @(negedge clk);
    rd_sel = SW'(12);
    #1;
    chk("rd_oob", rd_data, 0);

    // step 1-0-0-1-0-1 during a LOAD
    pat = 6'b101001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      step = pat[i];
      if (i == 0) begin
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = OP_LOAD;
        bif.cmd_dst   = SW'(5);
        bif.ext_data  = 16'hA5A5;
      end else if (i == 1) begin
        bif.cmd_dst  = SW'(6);
        bif.ext_data = 16'h6666;
      end
      @(negedge clk);
      chk($sformatf("stp_done%0d", i),
          bif.done, (i == 5));
      if (i == 3) chk("stp_bus", bif.bus, 16'hA5A5);
      if (i < 5) chk($sformatf("stp_rdy%0d", i),
                     bif.cmd_ready, 0);
      if (i < 5) begin
        step = 1'b0;
      end else begin
        bif.cmd_valid = 1'b0;
        step = 1'b0;
      end
    end
    m[5] = 16'hA5A5;
    @(negedge clk);
    chk("stp_clr", bif.done, 0);
    chk("stp_ready", bif.cmd_ready, 1);
    step = 1'b1;
    check_all();

    // reset while in LATCH, before the write edge
    run_cmd(OP_LOAD, 0, 4, 16'hFFFF);
    run_cmd(OP_INC, 4, 4, '0);
    @(negedge clk);
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = OP_LOAD;
    bif.cmd_dst   = SW'(8);
    bif.ext_data  = 16'h1234;
    step          = 1'b1;
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_bus", bif.bus, 16'h1234);
    rd_sel = SW'(3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_bus", bif.bus, 0);
    chk("arst_carry", bif.carry, 0);
    chk("arst_done", bif.done, 0);
    chk("arst_err", bif.err, 0);
    chk("arst_rd", rd_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) m[i] = '0;
    m_carry = 1'b0;
    @(negedge clk);
    chk("rel_ready", bif.cmd_ready, 1);
    chk("rel_done", bif.done, 0);
    check_all();
    run_cmd(OP_LOAD, 0, 0, 16'hBEEF);
    run_cmd(OP_MOV, 0, 8, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
